// File: rtl/ber_pkg.sv
// ber_pkg: shared widths, FSM state type and popcount helper for the BER counter.
// Optional feature macro used by this slice: BER_TOTAL_BITS_EN (adds the Bits accumulator).
package ber_pkg;
    localparam int WIDTH = 12;
    localparam int CNT_W = 50;
    localparam int AW    = 3;
    localparam int PCW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} ber_state_t;

    function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] v);
        popcount = '0;
        for (int i = 0; i < WIDTH; i++) popcount = popcount + PCW'(v[i]);
    endfunction
endpackage

// File: rtl/ber_counter_if.sv
// ber_counter_if: word streams, soft clear and result flags of the BER counter.
// master drives tx/rx words, valids and clear; slave (the counter) drives
// Errors, Error_flag, overflow, underrun, saturated and, with BER_TOTAL_BITS_EN, Bits.
interface ber_counter_if import ber_pkg::*; #(
    parameter int WIDTH = ber_pkg::WIDTH,
    parameter int CNT_W = ber_pkg::CNT_W
);
    logic [WIDTH-1:0] tx_word;
    logic             tx_valid;
    logic [WIDTH-1:0] rx_word;
    logic             rx_valid;
    logic             clear;
    logic [CNT_W-1:0] Errors;
    logic             Error_flag;
    logic             overflow;
    logic             underrun;
    logic             saturated;
`ifdef BER_TOTAL_BITS_EN
    logic [CNT_W-1:0] Bits;
    modport master (output tx_word, tx_valid, rx_word, rx_valid, clear,
                     input Errors, Error_flag, overflow, underrun, saturated, Bits);
    modport slave  (input tx_word, tx_valid, rx_word, rx_valid, clear,
                     output Errors, Error_flag, overflow, underrun, saturated, Bits);
`else
    modport master (output tx_word, tx_valid, rx_word, rx_valid, clear,
                     input Errors, Error_flag, overflow, underrun, saturated);
    modport slave  (input tx_word, tx_valid, rx_word, rx_valid, clear,
                     output Errors, Error_flag, overflow, underrun, saturated);
`endif
endinterface

// File: rtl/ber_align_fifo.sv
// ber_align_fifo: synchronous alignment FIFO holding transmitted words until decoded.
// Ports: clk, rst (sync, active-high), push/din, pop, head (current oldest word), full, empty.
// An extra pointer MSB separates full from empty; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ber_align_fifo import ber_pkg::*; #(
    parameter int WIDTH = ber_pkg::WIDTH,
    parameter int AW    = ber_pkg::AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/ber_counter.sv
// ber_counter: compares decoded words against buffered transmitted words and accumulates bit errors.
// Ports: CLK, reset (sync, active-low), bus (ber_counter_if.slave: tx/rx streams, clear, results).
// Macro BER_TOTAL_BITS_EN adds the Bits accumulator (WIDTH per compare, saturating).
module ber_counter import ber_pkg::*; #(
    parameter int WIDTH = ber_pkg::WIDTH,
    parameter int CNT_W = ber_pkg::CNT_W,
    parameter int AW    = ber_pkg::AW
) (
    input  logic         CLK,
    input  logic         reset,
    ber_counter_if.slave bus
);
    ber_state_t       state;
    logic [WIDTH-1:0] head;
    logic             full, empty, rst, cmp;
    logic [PCW-1:0]   d;
    logic [CNT_W:0]   err_sum;
    logic [CNT_W-1:0] errors;
    logic             error_flag, overflow, underrun, saturated;

    // clear behaves exactly like reset, including flushing the FIFO
    assign rst     = !reset || bus.clear;
    assign cmp     = state == RUN && bus.rx_valid && !empty;
    assign d       = popcount(bus.rx_word ^ head);
    assign err_sum = {1'b0, errors} + (CNT_W+1)'(d);

    ber_align_fifo #(.WIDTH(WIDTH), .AW(AW)) u_fifo (
        .clk   (CLK),
        .rst   (rst),
        .push  (bus.tx_valid),
        .pop   (bus.rx_valid),
        .din   (bus.tx_word),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef BER_TOTAL_BITS_EN
    logic [CNT_W-1:0] bits;
    logic [CNT_W:0]   bits_sum;
    assign bits_sum = {1'b0, bits} + (CNT_W+1)'(WIDTH);
    assign bus.Bits = bits;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            state      <= IDLE;
            errors     <= '0;
            error_flag <= 1'b0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
            saturated  <= 1'b0;
`ifdef BER_TOTAL_BITS_EN
            bits       <= '0;
`endif
        end else begin
            error_flag <= cmp && d != '0;
            // a full FIFO always has a head, so any rx_valid frees the slot
            if (bus.tx_valid && full && !bus.rx_valid) overflow <= 1'b1;
            if (state == IDLE && bus.tx_valid) state <= RUN;
            if (cmp) begin
                errors <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
`ifdef BER_TOTAL_BITS_EN
                bits   <= bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
`endif
                if (err_sum[CNT_W] || &err_sum[CNT_W-1:0]) begin
                    saturated <= 1'b1;
                    state     <= HALT;
                end
            end
            // underrun takes priority over the IDLE->RUN move of a same-cycle push
            if (bus.rx_valid && empty) begin
                underrun <= 1'b1;
                state    <= HALT;
            end
        end
    end

    assign bus.Errors     = errors;
    assign bus.Error_flag = error_flag;
    assign bus.overflow   = overflow;
    assign bus.underrun   = underrun;
    assign bus.saturated  = saturated;
endmodule

// File: tb/tb_ber_counter.sv
// tb_ber_counter: scoreboard bench for ber_counter (default CNT_W plus a CNT_W=4 instance).
module tb_ber_counter;
    import ber_pkg::*;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    ber_counter_if u_if ();
    ber_counter_if #(.CNT_W(4)) u_if4 ();

    ber_counter dut (.CLK(CLK), .reset(reset), .bus(u_if));
    ber_counter #(.CNT_W(4)) dut4 (.CLK(CLK), .reset(reset), .bus(u_if4));

    typedef struct {
        logic [49:0] err;
        logic        flag;
        logic        of;
        logic        uf;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] m_q[$];
    int          m_state;
    logic [49:0] m_err;
    logic        m_of, m_uf;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] w[9];

    task automatic model_reset();
        m_q.delete();
        sb.delete();
        m_state = 0;
        m_err   = '0;
        m_of    = 1'b0;
        m_uf    = 1'b0;
    endtask

    // one clock: drive, predict into the scoreboard, then pop and compare after the edge
    task automatic step(input logic tv, input logic [11:0] tw, input logic rv, input logic [11:0] rw);
        exp_t        e;
        logic [11:0] h;
        u_if.tx_valid = tv;
        u_if.tx_word  = tw;
        u_if.rx_valid = rv;
        u_if.rx_word  = rw;
        e.flag = 1'b0;
        if (tv && m_q.size() == 8 && !rv) m_of = 1'b1;
        if (rv) begin
            if (m_q.size() == 0) begin
                m_uf    = 1'b1;
                m_state = 2;
            end else begin
                h = m_q.pop_front();
                if (m_state == 1) begin
                    m_err  = m_err + 50'($countones(rw ^ h));
                    e.flag = rw != h;
                end
            end
        end
        if (tv && m_q.size() < 8) begin
            m_q.push_back(tw);
            if (m_state == 0) m_state = 1;
        end
        e.err = m_err;
        e.of  = m_of;
        e.uf  = m_uf;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        u_if.tx_valid = 1'b0;
        u_if.rx_valid = 1'b0;
        e = sb.pop_front();
        n_checks += 4;
        if (u_if.Errors !== e.err) begin
            n_errors++;
            $display("FAIL step_errors: got %0d expected %0d", u_if.Errors, e.err);
        end
        if (u_if.Error_flag !== e.flag) begin
            n_errors++;
            $display("FAIL step_error_flag: got %b expected %b", u_if.Error_flag, e.flag);
        end
        if (u_if.overflow !== e.of) begin
            n_errors++;
            $display("FAIL step_overflow: got %b expected %b", u_if.overflow, e.of);
        end
        if (u_if.underrun !== e.uf) begin
            n_errors++;
            $display("FAIL step_underrun: got %b expected %b", u_if.underrun, e.uf);
        end
    endtask

    task automatic do_clear(input logic rv);
        u_if.clear    = 1'b1;
        u_if.rx_valid = rv;
        u_if.rx_word  = 12'hFFF;
        @(posedge CLK);
        #1;
        u_if.clear    = 1'b0;
        u_if.rx_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_checks += 3;
        if ({u_if.Errors, u_if.Error_flag, u_if.overflow, u_if.underrun, u_if.saturated} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {u_if.Errors, u_if.Error_flag, u_if.overflow, u_if.underrun, u_if.saturated});
        end
        if (dut.state !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state: got %0d expected IDLE", dut.state);
        end
        if ({u_if4.Errors, u_if4.saturated} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs4: got %h expected 0", {u_if4.Errors, u_if4.saturated});
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_match();
        step(1'b1, 12'h66A, 1'b0, 12'h000);
        step(1'b0, 12'h000, 1'b1, 12'h66A);
        n_checks += 2;
        if (u_if.Errors !== 50'd0) begin
            n_errors++;
            $display("FAIL match_errors: got %0d expected 0", u_if.Errors);
        end
        if (dut.state !== RUN) begin
            n_errors++;
            $display("FAIL match_state: got %0d expected RUN", dut.state);
        end
    endtask

    task automatic test_errors();
        step(1'b1, 12'hE6A, 1'b0, 12'h000);
        step(1'b1, 12'hEFA, 1'b0, 12'h000);
        step(1'b1, 12'h0F8, 1'b0, 12'h000);
        step(1'b0, 12'h000, 1'b1, 12'hE6B);
        step(1'b0, 12'h000, 1'b1, 12'hEFA);
        step(1'b0, 12'h000, 1'b1, 12'h0F0);
        n_checks++;
        if (u_if.Errors !== 50'd2) begin
            n_errors++;
            $display("FAIL errors_total: got %0d expected 2", u_if.Errors);
        end
    endtask

    task automatic test_overflow();
        do_clear(1'b0);
        for (int i = 0; i < 9; i++) begin
            w[i] = 12'($urandom);
            step(1'b1, w[i], 1'b0, 12'h000);
            if (i == 7) begin
                n_checks++;
                if (u_if.overflow !== 1'b0) begin
                    n_errors++;
                    $display("FAIL overflow_early: got %b expected 0", u_if.overflow);
                end
            end
        end
        n_checks++;
        if (u_if.overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_set: got %b expected 1", u_if.overflow);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 12'h000, 1'b1, w[i] ^ (i[0] ? 12'(1 << i) : 12'h000));
        n_checks += 2;
        if (u_if.Errors !== 50'd4) begin
            n_errors++;
            $display("FAIL overflow_order_errors: got %0d expected 4", u_if.Errors);
        end
        if (dut.u_fifo.empty !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_drained: got %b expected 1", dut.u_fifo.empty);
        end
    endtask

    task automatic test_underrun();
        do_clear(1'b0);
        step(1'b0, 12'h000, 1'b1, 12'h000);
        n_checks++;
        if (dut.state !== HALT) begin
            n_errors++;
            $display("FAIL underrun_state: got %0d expected HALT", dut.state);
        end
        step(1'b1, 12'h123, 1'b0, 12'h000);
        step(1'b0, 12'h000, 1'b1, 12'h321);
        n_checks++;
        if (u_if.Errors !== 50'd0) begin
            n_errors++;
            $display("FAIL halt_no_accum: got %0d expected 0", u_if.Errors);
        end
        do_clear(1'b0);
        n_checks += 2;
        if ({u_if.Errors, u_if.Error_flag, u_if.overflow, u_if.underrun, u_if.saturated} !== '0) begin
            n_errors++;
            $display("FAIL clear_outputs: got %h expected 0",
                     {u_if.Errors, u_if.Error_flag, u_if.overflow, u_if.underrun, u_if.saturated});
        end
        if (dut.state !== IDLE) begin
            n_errors++;
            $display("FAIL clear_state: got %0d expected IDLE", dut.state);
        end
    endtask

    task automatic test_saturate();
        u_if4.tx_valid = 1'b1;
        u_if4.tx_word  = 12'hFFF;
        repeat (3) @(posedge CLK);
        #1;
        u_if4.tx_valid = 1'b0;
        u_if4.rx_valid = 1'b1;
        u_if4.rx_word  = 12'h000;
        @(posedge CLK);
        #1;
        n_checks += 2;
        if (u_if4.Errors !== 4'd12) begin
            n_errors++;
            $display("FAIL sat_first: got %0d expected 12", u_if4.Errors);
        end
        if (u_if4.saturated !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_early: got %b expected 0", u_if4.saturated);
        end
        @(posedge CLK);
        #1;
        n_checks += 3;
        if (u_if4.Errors !== 4'd15) begin
            n_errors++;
            $display("FAIL sat_value: got %0d expected 15", u_if4.Errors);
        end
        if (u_if4.saturated !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_flag: got %b expected 1", u_if4.saturated);
        end
        if (dut4.state !== HALT) begin
            n_errors++;
            $display("FAIL sat_state: got %0d expected HALT", dut4.state);
        end
        @(posedge CLK);
        #1;
        u_if4.rx_valid = 1'b0;
        n_checks += 2;
        if (u_if4.Errors !== 4'd15) begin
            n_errors++;
            $display("FAIL sat_hold: got %0d expected 15", u_if4.Errors);
        end
        if (u_if4.Error_flag !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_halt_flag: got %b expected 0", u_if4.Error_flag);
        end
    endtask

    task automatic test_back_to_back();
        do_clear(1'b0);
        for (int i = 0; i < 8; i++) begin
            w[i] = 12'($urandom);
            step(1'b1, w[i], 1'b0, 12'h000);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 12'($urandom), 1'b1, w[i] ^ 12'h800);
        n_checks += 3;
        if (dut.u_fifo.full !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_full: got %b expected 1", dut.u_fifo.full);
        end
        if (u_if.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_overflow: got %b expected 0", u_if.overflow);
        end
        if (u_if.Errors !== 50'd4) begin
            n_errors++;
            $display("FAIL b2b_errors: got %0d expected 4", u_if.Errors);
        end
        do_clear(1'b1);
        n_checks += 3;
        if ({u_if.Errors, u_if.Error_flag} !== '0) begin
            n_errors++;
            $display("FAIL clear_cmp_outputs: got %h expected 0", {u_if.Errors, u_if.Error_flag});
        end
        if (dut.u_fifo.empty !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_cmp_empty: got %b expected 1", dut.u_fifo.empty);
        end
        if (dut.state !== IDLE) begin
            n_errors++;
            $display("FAIL clear_cmp_state: got %0d expected IDLE", dut.state);
        end
    endtask

    initial begin
        u_if.tx_valid  = 1'b0;
        u_if.tx_word   = '0;
        u_if.rx_valid  = 1'b0;
        u_if.rx_word   = '0;
        u_if.clear     = 1'b0;
        u_if4.tx_valid = 1'b0;
        u_if4.tx_word  = '0;
        u_if4.rx_valid = 1'b0;
        u_if4.rx_word  = '0;
        u_if4.clear    = 1'b0;
        test_reset();
        test_match();
        test_errors();
        test_overflow();
        test_underrun();
        test_saturate();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ber_counter.md
# ber_counter

Bit-error-rate counter sitting directly downstream of the encode/channel/decode chain. It buffers each transmitted 12-bit word until the matching decoded word arrives, XORs the pair, popcounts the difference and accumulates a 50-bit error total, a word-error flag and sticky fault flags. It replaces ad-hoc bench-side comparison and gives the BER bench a synthesizable checker with its own FIFO alignment.

## Interface
- `WIDTH`, 12: data word width.
- `CNT_W`, 50: error and bit accumulator width.
- `AW`, 3: alignment FIFO address width (depth 2^AW = 8 words).
- `CLK` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `tx_word` in WIDTH: word entering the chain (same value as the chain's `IN`).
- `tx_valid` in 1: push `tx_word` into the FIFO.
- `rx_word` in WIDTH: decoded word leaving the chain (`OUT`).
- `rx_valid` in 1: compare `rx_word` against the FIFO head and pop.
- `clear` in 1: synchronous soft clear.
- `Errors` out CNT_W: accumulated bit errors.
- `Error_flag` out 1: one-cycle pulse; the previous compare had at least one bit error.
- `overflow` out 1: sticky; push attempted while the FIFO was full.
- `underrun` out 1: sticky; `rx_valid` arrived while the FIFO was empty.
- `saturated` out 1: sticky; `Errors` reached all-ones.
- `Bits` out CNT_W: total compared bits. Present only with `BER_TOTAL_BITS_EN`.

## Operation
- FSM states:
  - IDLE: FIFO empty, no word pushed since reset or clear. First `tx_valid` moves to RUN.
  - RUN: normal counting.
  - HALT: entered from RUN on underrun or saturation. In HALT, compares and accumulation stop; pushes and pops still move the FIFO. Only reset or `clear` leaves HALT, to IDLE.
- Push: on `tx_valid` with FIFO not full, `tx_word` is written at the tail. On `tx_valid` with FIFO full and no pop in the same cycle, the word is dropped and `overflow` is set.
- Compare: on `rx_valid` with FIFO not empty, in RUN:
  - `d = popcount(rx_word ^ head)`, range 0..WIDTH, zero-extended to CNT_W.
  - `Errors <= Errors + d`, saturating at 2^CNT_W−1. Reaching the saturation value sets `saturated`; next state is HALT.
  - `Error_flag <= (d != 0)`.
- Underrun: `rx_valid` with FIFO empty does no compare and no pop, sets `underrun` and forces HALT. In IDLE this also applies: HALT plus `underrun`.
- Simultaneous push and pop:
  - FIFO full: both are legal, occupancy unchanged, no overflow.
  - FIFO empty: no bypass. The pop is an underrun, the push is accepted.
- `clear` and active reset act identically. FIFO empty, pointers 0, `Errors`/`Bits` 0, all flags 0, state IDLE. `clear` wins over any same-cycle push or compare.
- Reset mid-operation discards all buffered words. No partial update survives.

## Timing
- Reset values: `Errors`=0, `Bits`=0, `Error_flag`=0, `overflow`=0, `underrun`=0, `saturated`=0, state IDLE.
- Compare latency is 1 cycle. `rx_valid` sampled at edge n; `Errors` and `Error_flag` are valid after edge n+1.
- `Error_flag` is high for exactly one cycle per erroneous compare and is 0 in any cycle without a compare.
- A word pushed at edge n can be popped at edge n+1 or later.
- Pointers wrap modulo 2^AW. Full and empty are distinguished by an extra pointer MSB.
- All outputs are registered. There is no combinational input-to-output path.

## Configuration
- `BER_TOTAL_BITS_EN` defined: the `Bits` port exists. It adds WIDTH per valid compare in RUN and saturates at all-ones. The BER is then `Errors/Bits`, computed in the bench.
- `BER_TOTAL_BITS_EN` undefined: no `Bits` port and no register. All other behaviour is identical.

## Structure
- Package `ber_pkg` holds:
  - `WIDTH` and `CNT_W` defaults.
  - The FSM state enum `ber_state_t` {IDLE, RUN, HALT}.
  - A `popcount` function sized by WIDTH.
- Sub-module `ber_align_fifo`: a synchronous FIFO with push/pop, full/empty and the pointer-MSB scheme. `ber_counter` instantiates it once and holds the FSM, popcount and accumulators.

## Test plan
- Reset, then push 12'h66A and compare with 12'h66A → `Errors`=0, `Error_flag` never high, state RUN.
- Push 12'hE6A, 12'hEFA, 12'h0F8, then compare with 12'hE6B, 12'hEFA, 12'h0F0 → `Errors` 1, 1, 2. `Error_flag` pulses on the 1st and 3rd compares only.
- Push 9 words with no pops → `overflow`=1 after the 9th. The 8 stored words then compare in order.
- `rx_valid` with the FIFO empty → `underrun`=1, state HALT. Further compares leave `Errors` unchanged until `clear`, after which all outputs are 0 and the state is IDLE.
- Run with CNT_W=4: repeated compares of 12'hFFF against 12'h000 → `Errors` 12, then 15, `saturated`=1, state HALT.
- Full FIFO with same-cycle push and pop → occupancy stays 8, no `overflow`. A `clear` asserted together with `rx_valid` → no accumulation.
